// File: rtl/note_pkg.sv
// Shared widths and the note-to-phase-step table for the voice players.
// Steps are round(f_note * 2^20 / 48000) with note 49 = A4 = 440 Hz.
package note_pkg;

   localparam int unsigned PHASE_W  = 20;
   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned NOTE_W   = 6;
   localparam int unsigned DUR_W    = 6;

   function automatic logic [PHASE_W-1:0] step_of(input logic [NOTE_W-1:0] n);
      logic [PHASE_W-1:0] s;
      case (n)
         6'd1:  s = 20'd601;   6'd2:  s = 20'd636;   6'd3:  s = 20'd674;   6'd4:  s = 20'd714;
         6'd5:  s = 20'd757;   6'd6:  s = 20'd802;   6'd7:  s = 20'd850;   6'd8:  s = 20'd900;
         6'd9:  s = 20'd954;   6'd10: s = 20'd1010;  6'd11: s = 20'd1070;  6'd12: s = 20'd1134;
         6'd13: s = 20'd1201;  6'd14: s = 20'd1273;  6'd15: s = 20'd1349;  6'd16: s = 20'd1429;
         6'd17: s = 20'd1514;  6'd18: s = 20'd1604;  6'd19: s = 20'd1699;  6'd20: s = 20'd1800;
         6'd21: s = 20'd1907;  6'd22: s = 20'd2021;  6'd23: s = 20'd2141;  6'd24: s = 20'd2268;
         6'd25: s = 20'd2403;  6'd26: s = 20'd2546;  6'd27: s = 20'd2697;  6'd28: s = 20'd2858;
         6'd29: s = 20'd3028;  6'd30: s = 20'd3208;  6'd31: s = 20'd3398;  6'd32: s = 20'd3600;
         6'd33: s = 20'd3815;  6'd34: s = 20'd4041;  6'd35: s = 20'd4282;  6'd36: s = 20'd4536;
         6'd37: s = 20'd4806;  6'd38: s = 20'd5092;  6'd39: s = 20'd5395;  6'd40: s = 20'd5715;
         6'd41: s = 20'd6055;  6'd42: s = 20'd6415;  6'd43: s = 20'd6797;  6'd44: s = 20'd7201;
         6'd45: s = 20'd7629;  6'd46: s = 20'd8083;  6'd47: s = 20'd8563;  6'd48: s = 20'd9072;
         6'd49: s = 20'd9612;  6'd50: s = 20'd10184; 6'd51: s = 20'd10789; 6'd52: s = 20'd11431;
         6'd53: s = 20'd12110; 6'd54: s = 20'd12830; 6'd55: s = 20'd13593; 6'd56: s = 20'd14402;
         6'd57: s = 20'd15258; 6'd58: s = 20'd16165; 6'd59: s = 20'd17127; 6'd60: s = 20'd18145;
         6'd61: s = 20'd19224; 6'd62: s = 20'd20367; 6'd63: s = 20'd21578;
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/note_player_if.sv
// Codec sample handshake: the codec requests, the player answers one cycle later.
interface note_player_if;
   import note_pkg::*;

   logic                generate_next_sample;
   logic [SAMPLE_W-1:0] sample_out;
   logic                new_sample_ready;

   modport master (output generate_next_sample, input sample_out, new_sample_ready);
   modport slave  (input generate_next_sample, output sample_out, new_sample_ready);
endinterface

// File: rtl/note_dur_counter.sv
// Beat-driven duration countdown; raises done for one cycle when a note expires.
module note_dur_counter
   import note_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             play_enable,
   input  logic             load,
   input  logic [DUR_W-1:0] duration,
   input  logic             beat,
   output logic             active,
   output logic             done
);

   logic [DUR_W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (!reset) begin
         remaining <= '0;
         active    <= 1'b0;
         done      <= 1'b0;
      end else if (load) begin
         // A zero-length note expires immediately so the reader never stalls on it.
         remaining <= duration;
         active    <= (duration != '0);
         done      <= (duration == '0);
      end else if (beat && play_enable && active) begin
         remaining <= remaining - 1'b1;
         active    <= (remaining != DUR_W'(1));
         done      <= (remaining == DUR_W'(1));
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/note_player.sv
// One voice: holds a note for its duration and answers codec requests with
// a sawtooth sample from a phase accumulator.
module note_player
   import note_pkg::*;
#(
   parameter int unsigned PHASE_W  = note_pkg::PHASE_W,
   parameter int unsigned SAMPLE_W = note_pkg::SAMPLE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_enable,
   input  logic              load,
   input  logic [NOTE_W-1:0] note,
   input  logic [DUR_W-1:0]  duration,
   input  logic              beat,
   note_player_if.slave      codec,
   output logic              done,
   output logic              active
);

   localparam logic [SAMPLE_W-1:0] SIGN_FLIP = {1'b1, {(SAMPLE_W-1){1'b0}}};

   logic [NOTE_W-1:0]  note_q;
   logic [PHASE_W-1:0] phase;
   logic [PHASE_W-1:0] step;
   logic [PHASE_W-1:0] phase_next;

   // Step is a pure function of the held note, so it is derived rather than stored.
   assign step       = PHASE_W'(step_of(note_q));
   assign phase_next = phase + step;

   note_dur_counter u_dur (
      .clk         (clk),
      .reset       (reset),
      .play_enable (play_enable),
      .load        (load),
      .duration    (duration),
      .beat        (beat),
      .active      (active),
      .done        (done)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         note_q                 <= '0;
         phase                  <= '0;
         codec.sample_out       <= '0;
         codec.new_sample_ready <= 1'b0;
      end else begin
         codec.new_sample_ready <= codec.generate_next_sample;
         if (load) begin
            note_q <= note;
            phase  <= '0;
            if (codec.generate_next_sample)
               codec.sample_out <= '0;
         end else if (codec.generate_next_sample) begin
            if (play_enable && active) begin
               phase            <= phase_next;
               codec.sample_out <= phase_next[PHASE_W-1 -: SAMPLE_W] ^ SIGN_FLIP;
            end else begin
               codec.sample_out <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_note_player.sv
// Directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_note_player;

   logic       clk = 1'b0;
   logic       reset;
   logic       play_enable;
   logic       load;
   logic [5:0] note;
   logic [5:0] duration;
   logic       beat;
   logic       done;
   logic       active;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   note_player_if bus ();

   note_player #(.PHASE_W(20), .SAMPLE_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .play_enable (play_enable),
      .load        (load),
      .note        (note),
      .duration    (duration),
      .beat        (beat),
      .codec       (bus.slave),
      .done        (done),
      .active      (active)
   );

   always #5 clk = ~clk;

   // Model state: remaining beats, phase, step; plus expected registered outputs.
   int unsigned m_rem, m_phase, m_step;
   logic [15:0] e_sample;
   logic        e_rdy, e_done, e_act;

   function automatic int unsigned ref_step(input int n);
      real f;
      if (n == 0) return 0;
      f = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 1048576.0 / 48000.0;
      return $rtoi(f + 0.5);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst_n, pe, ld, input int n, d, input logic bt, gen);
      bit running;
      if (!rst_n) begin
         m_rem = 0; m_phase = 0; m_step = 0;
         e_sample = '0; e_rdy = 0; e_done = 0; e_act = 0;
         return;
      end
      e_rdy = gen;
      if (ld) begin
         if (gen) e_sample = '0;
         m_phase = 0;
         m_step  = ref_step(n);
         m_rem   = d;
         e_done  = (d == 0);
      end else begin
         running = pe && (m_rem > 0);
         if (gen) begin
            if (running) begin
               m_phase  = (m_phase + m_step) % (1 << 20);
               e_sample = 16'((m_phase >> 4) ^ 32'h8000);
            end else begin
               e_sample = '0;
            end
         end
         e_done = 0;
         if (bt && running) begin
            m_rem--;
            if (m_rem == 0) e_done = 1;
         end
      end
      e_act = (m_rem > 0);
   endtask

   task automatic apply(input logic rst_n, pe, ld, input int n, d, input logic bt, gen);
      reset       = rst_n;
      play_enable = pe;
      load        = ld;
      note        = 6'(n);
      duration    = 6'(d);
      beat        = bt;
      bus.generate_next_sample = gen;
      @(posedge clk);
      #1;
      model_step(rst_n, pe, ld, n, d, bt, gen);
      check("sample", 32'(bus.sample_out), 32'(e_sample));
      check("ready",  32'(bus.new_sample_ready), 32'(e_rdy));
      check("done",   32'(done), 32'(e_done));
      check("active", 32'(active), 32'(e_act));
   endtask

   task automatic idle(input logic pe);
      apply(1, pe, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 0; play_enable = 0; load = 0; note = '0; duration = '0; beat = 0;
      bus.generate_next_sample = 0;
      #1;
      apply(0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0);
      check("rst_sample", 32'(bus.sample_out), 32'h0);
      check("rst_active", 32'(active), 32'h0);

      // A4 for two beats, three samples
      apply(1, 1, 1, 49, 2, 0, 0);
      check("a4_active", 32'(active), 32'h1);
      apply(1, 1, 0, 0, 0, 0, 1);
      check("a4_s1", 32'(bus.sample_out), 32'h8258);
      idle(1);
      apply(1, 1, 0, 0, 0, 0, 1);
      check("a4_s2", 32'(bus.sample_out), 32'h84B1);
      apply(1, 1, 0, 0, 0, 0, 1);
      check("a4_s3", 32'(bus.sample_out), 32'h870A);
      check("a4_rdy3", 32'(bus.new_sample_ready), 32'h1);
      apply(1, 1, 0, 0, 0, 1, 0);
      apply(1, 1, 0, 0, 0, 1, 0);
      check("a4_done", 32'(done), 32'h1);
      check("a4_inactive", 32'(active), 32'h0);
      idle(1);
      apply(1, 1, 0, 0, 0, 0, 1);
      check("post_sample", 32'(bus.sample_out), 32'h0);

      // Paused beats are ignored
      apply(1, 1, 1, 30, 3, 0, 0);
      apply(1, 0, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 0, 1, 1);
      check("pause_hold", 32'(active), 32'h1);
      for (int i = 0; i < 3; i++) apply(1, 1, 0, 0, 0, 1, 0);
      check("resume_done", 32'(done), 32'h1);
      idle(1);

      // Zero duration
      apply(1, 1, 1, 12, 0, 0, 0);
      check("zero_done", 32'(done), 32'h1);
      idle(1);

      // Reload while active, beat in the same cycle is ignored
      apply(1, 1, 1, 20, 5, 0, 0);
      apply(1, 1, 0, 0, 0, 1, 1);
      apply(1, 1, 0, 0, 0, 1, 1);
      apply(1, 1, 1, 49, 1, 1, 0);
      check("reload_nodone", 32'(done), 32'h0);
      apply(1, 1, 0, 0, 0, 0, 1);
      check("reload_phase0", 32'(bus.sample_out), 32'h8258);
      apply(1, 1, 0, 0, 0, 1, 1);
      check("reload_done", 32'(done), 32'h1);
      idle(1);

      // Reset mid-note
      apply(1, 1, 1, 40, 4, 0, 0);
      apply(1, 1, 0, 0, 0, 0, 1);
      apply(0, 1, 0, 0, 0, 1, 1);
      check("midrst_done", 32'(done), 32'h0);
      for (int i = 0; i < 4; i++) apply(1, 1, 0, 0, 0, 1, 0);

      // Rest note: constant mid-scale sample while active
      apply(1, 1, 1, 0, 2, 0, 0);
      apply(1, 1, 0, 0, 0, 0, 1);
      check("rest_sample", 32'(bus.sample_out), 32'h8000);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         apply($urandom_range(0, 299) != 0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 15) == 0, int'($urandom_range(0, 63)),
               int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
